// File: rtl/wb_pkg.sv
// Shared constants for the writeback stage: wb_sel encodings, opcodes,
// load funct3 codes and the default tohost CSR address.
package wb_pkg;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_CSR    = 7'b1110011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [11:0] CSR_TOHOST_DEFAULT = 12'h51E;

endpackage

// File: rtl/wb_stage_load_extract.sv
// Combinational load-data alignment: selects the addressed byte/halfword
// of the memory word and sign- or zero-extends it.
module load_extract
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfwords are naturally aligned, so only offset[1] picks the half.
  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  value = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   value = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  value = {{(XLEN-16){1'b0}}, half_sel};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Stage-3 writeback: holds the stage-2->3 pipeline register, selects the
// register-file write value, forwards it to stage 2, and owns tohost/instret.
module wb_stage
  import wb_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter logic [11:0] CSR_TOHOST = CSR_TOHOST_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            s2_valid,
  input  logic [XLEN-1:0] s2_pc,
  input  logic [XLEN-1:0] s2_alu,
  input  logic [4:0]      s2_rd,
  input  logic [6:0]      s2_opcode,
  input  logic [2:0]      s2_funct3,
  input  logic [11:0]     s2_csr_addr,
  input  logic [XLEN-1:0] s2_csr_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic [1:0]      wb_sel,
  input  logic            rwe,
  input  logic            csr_we,
  output logic [6:0]      s3_opcode,
  output logic [2:0]      s3_funct3,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic [XLEN-1:0] csr_tohost,
  output logic [31:0]     instret
);

  logic            s3_valid;
  logic [XLEN-1:0] s3_pc;
  logic [XLEN-1:0] s3_alu;
  logic [4:0]      s3_rd;
  logic [11:0]     s3_csr_addr;
  logic [XLEN-1:0] s3_csr_wdata;
  logic [XLEN-1:0] load_value;
  logic            retire;

  // A stall freezes the stage so the held instruction commits exactly once,
  // on the first unstalled edge, which is also when it leaves the stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_valid     <= 1'b0;
      s3_pc        <= '0;
      s3_alu       <= '0;
      s3_rd        <= '0;
      s3_opcode    <= '0;
      s3_funct3    <= '0;
      s3_csr_addr  <= '0;
      s3_csr_wdata <= '0;
    end else if (!stall) begin
      s3_valid     <= s2_valid;
      s3_pc        <= s2_pc;
      s3_alu       <= s2_alu;
      s3_rd        <= s2_rd;
      s3_opcode    <= s2_opcode;
      s3_funct3    <= s2_funct3;
      s3_csr_addr  <= s2_csr_addr;
      s3_csr_wdata <= s2_csr_wdata;
    end
  end

  load_extract #(.XLEN(XLEN)) u_load_extract (
    .rdata  (dmem_rdata),
    .offset (s3_alu[1:0]),
    .funct3 (s3_funct3),
    .value  (load_value)
  );

  always_comb begin
    case (wb_sel)
      WB_MEM:  rf_wdata = load_value;
      WB_ALU:  rf_wdata = s3_alu;
      WB_PC4:  rf_wdata = s3_pc + XLEN'(4);
      default: rf_wdata = 'x;
    endcase
  end

  assign retire    = s3_valid & ~stall;
  assign rf_we     = retire & rwe & (s3_rd != 5'd0);
  assign rf_waddr  = s3_rd;
  // Forwarding ignores stall so a frozen stage 2 can still pick up the value.
  assign fwd_valid = s3_valid & rwe & (s3_rd != 5'd0);
  assign fwd_rd    = s3_rd;
  assign fwd_data  = rf_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csr_tohost <= '0;
      instret    <= '0;
    end else begin
      if (retire && csr_we && (s3_csr_addr == CSR_TOHOST))
        csr_tohost <= s3_csr_wdata;
      if (retire)
        instret <= instret + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: load extraction, PC+4, CSR
// tohost, stall hold/commit, async reset and instret counting.
module tb_wb_stage;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        s2_valid;
  logic [31:0] s2_pc, s2_alu, s2_csr_wdata, dmem_rdata;
  logic [4:0]  s2_rd;
  logic [6:0]  s2_opcode;
  logic [2:0]  s2_funct3;
  logic [11:0] s2_csr_addr;
  logic [1:0]  wb_sel;
  logic        rwe, csr_we;
  logic [6:0]  s3_opcode;
  logic [2:0]  s3_funct3;
  logic        rf_we, fwd_valid;
  logic [4:0]  rf_waddr, fwd_rd;
  logic [31:0] rf_wdata, fwd_data, csr_tohost, instret;

  int checks = 0;
  int failures = 0;

  wb_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .s2_valid(s2_valid),
    .s2_pc(s2_pc), .s2_alu(s2_alu), .s2_rd(s2_rd), .s2_opcode(s2_opcode),
    .s2_funct3(s2_funct3), .s2_csr_addr(s2_csr_addr),
    .s2_csr_wdata(s2_csr_wdata), .dmem_rdata(dmem_rdata), .wb_sel(wb_sel),
    .rwe(rwe), .csr_we(csr_we), .s3_opcode(s3_opcode), .s3_funct3(s3_funct3),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .csr_tohost(csr_tohost), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Loads one instruction into stage 3 (clears controls for the one leaving).
  task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3,
                               input logic [31:0] pc, input logic [31:0] alu,
                               input logic [4:0] rd, input logic [11:0] caddr,
                               input logic [31:0] cdata);
    stall        = 1'b0;
    rwe          = 1'b0;
    csr_we       = 1'b0;
    wb_sel       = WB_ALU;
    s2_valid     = 1'b1;
    s2_opcode    = opc;
    s2_funct3    = f3;
    s2_pc        = pc;
    s2_alu       = alu;
    s2_rd        = rd;
    s2_csr_addr  = caddr;
    s2_csr_wdata = cdata;
    @(posedge clk);
    #1;
    s2_valid = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  task automatic checkLoad(input string tag, input logic [2:0] f3,
                           input logic [31:0] alu, input logic [31:0] expected);
    applyStimulus(OPC_LOAD, f3, 32'h0, alu, 5'd3, 12'h0, 32'h0);
    dmem_rdata = 32'h80FF1234;
    wb_sel     = WB_MEM;
    rwe        = 1'b1;
    #1;
    checkOutput(tag, rf_wdata, expected);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; s2_valid = 1'b0; s2_pc = '0; s2_alu = '0;
    s2_rd = '0; s2_opcode = '0; s2_funct3 = '0; s2_csr_addr = '0;
    s2_csr_wdata = '0; dmem_rdata = '0; wb_sel = WB_ALU; rwe = 1'b1; csr_we = 1'b0;
    #2;
    checkOutput("reset_rf_we", {31'd0, rf_we}, 32'd0);
    checkOutput("reset_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    checkOutput("reset_s3_opcode", {25'd0, s3_opcode}, 32'd0);
    checkOutput("reset_instret", instret, 32'd0);
    checkOutput("reset_tohost", csr_tohost, 32'd0);
    #1 reset = 1'b0;

    // Load extraction
    checkLoad("lb_sign", F3_LB, 32'h1003, 32'hFFFFFF80);
    checkOutput("lb_rf_we", {31'd0, rf_we}, 32'd1);
    checkOutput("lb_waddr", {27'd0, rf_waddr}, 32'd3);
    checkOutput("lb_s3_opcode", {25'd0, s3_opcode}, {25'd0, OPC_LOAD});
    checkOutput("lb_s3_funct3", {29'd0, s3_funct3}, {29'd0, F3_LB});
    checkLoad("lbu_zero", F3_LBU, 32'h1003, 32'h00000080);
    checkLoad("lb_off1", F3_LB, 32'h1001, 32'h00000012);
    checkLoad("lh_upper", F3_LH, 32'h1002, 32'hFFFF80FF);
    checkLoad("lhu_odd", F3_LHU, 32'h1003, 32'h000080FF);
    checkLoad("lh_lower", F3_LH, 32'h1000, 32'h00001234);
    checkLoad("lw_word", F3_LW, 32'h1003, 32'h80FF1234);

    // JAL / PC+4
    applyStimulus(OPC_JAL, 3'd0, 32'h00002000, 32'h0, 5'd1, 12'h0, 32'h0);
    wb_sel = WB_PC4; rwe = 1'b1; #1;
    checkOutput("jal_rf_we", {31'd0, rf_we}, 32'd1);
    checkOutput("jal_waddr", {27'd0, rf_waddr}, 32'd1);
    checkOutput("jal_wdata", rf_wdata, 32'h00002004);
    checkOutput("jal_fwd_valid", {31'd0, fwd_valid}, 32'd1);
    checkOutput("jal_fwd_data", fwd_data, 32'h00002004);
    applyStimulus(OPC_JAL, 3'd0, 32'h00002000, 32'h0, 5'd0, 12'h0, 32'h0);
    wb_sel = WB_PC4; rwe = 1'b1; #1;
    checkOutput("jal_x0_rf_we", {31'd0, rf_we}, 32'd0);
    checkOutput("jal_x0_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    applyStimulus(OPC_JAL, 3'd0, 32'hFFFFFFFC, 32'h0, 5'd2, 12'h0, 32'h0);
    wb_sel = WB_PC4; rwe = 1'b1; #1;
    checkOutput("pc4_wrap", rf_wdata, 32'h0);

    // CSR tohost
    applyStimulus(OPC_CSR, 3'b001, 32'h0, 32'h0, 5'd0, 12'h51E, 32'h1);
    csr_we = 1'b1; #1;
    checkOutput("tohost_before_edge", csr_tohost, 32'h0);
    @(posedge clk); #1;
    checkOutput("tohost_written", csr_tohost, 32'h1);
    applyStimulus(OPC_CSR, 3'b001, 32'h0, 32'h0, 5'd0, 12'h51F, 32'h7);
    csr_we = 1'b1;
    @(posedge clk); #1;
    checkOutput("tohost_other_addr", csr_tohost, 32'h1);

    // Async reset mid-cycle with a valid ADD in stage 3
    applyStimulus(OPC_OP, 3'd0, 32'h0, 32'h55, 5'd5, 12'h0, 32'h0);
    wb_sel = WB_ALU; rwe = 1'b1; #1;
    checkOutput("add_rf_we_pre", {31'd0, rf_we}, 32'd1);
    reset = 1'b1; #1;
    checkOutput("arst_rf_we", {31'd0, rf_we}, 32'd0);
    checkOutput("arst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    checkOutput("arst_instret", instret, 32'd0);
    checkOutput("arst_tohost", csr_tohost, 32'd0);
    checkOutput("arst_s3_funct3", {29'd0, s3_funct3}, 32'd0);
    reset = 1'b0; #1;
    checkOutput("arst_no_write", {31'd0, rf_we}, 32'd0);
    @(posedge clk); #1;
    checkOutput("arst_no_write_edge", {31'd0, rf_we}, 32'd0);
    checkOutput("arst_no_count", instret, 32'd0);

    // LW held under stall for 3 cycles
    doReset();
    applyStimulus(OPC_LOAD, F3_LW, 32'h0, 32'h100, 5'd7, 12'h0, 32'h0);
    stall = 1'b1; dmem_rdata = 32'hCAFEBABE; wb_sel = WB_MEM; rwe = 1'b1;
    s2_valid = 1'b1; s2_alu = 32'hDEAD; s2_rd = 5'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("stall_rf_we_%0d", i), {31'd0, rf_we}, 32'd0);
      checkOutput($sformatf("stall_fwd_valid_%0d", i), {31'd0, fwd_valid}, 32'd1);
      checkOutput($sformatf("stall_fwd_rd_%0d", i), {27'd0, fwd_rd}, 32'd7);
      @(posedge clk); #1;
    end
    checkOutput("stall_fwd_data", fwd_data, 32'hCAFEBABE);
    checkOutput("stall_instret", instret, 32'd0);
    stall = 1'b0; s2_valid = 1'b0; #1;
    checkOutput("unstall_rf_we", {31'd0, rf_we}, 32'd1);
    checkOutput("unstall_waddr", {27'd0, rf_waddr}, 32'd7);
    checkOutput("unstall_wdata", rf_wdata, 32'hCAFEBABE);
    @(posedge clk); #1;
    checkOutput("unstall_once", {31'd0, rf_we}, 32'd0);
    checkOutput("unstall_instret", instret, 32'd1);
    @(posedge clk); #1;
    checkOutput("unstall_instret_hold", instret, 32'd1);

    // ADDI stream with one bubble
    doReset();
    wb_sel = WB_ALU; rwe = 1'b1; stall = 1'b0; s2_opcode = OPC_OP_IMM;
    s2_funct3 = 3'd0;
    for (int i = 0; i < 10; i++) begin
      s2_valid = (i != 4);
      s2_alu   = 32'h100 + i;
      s2_rd    = 5'(i + 1);
      @(posedge clk); #1;
      if (i != 4) begin
        checkOutput($sformatf("stream_wdata_%0d", i), rf_wdata, 32'h100 + i);
        checkOutput($sformatf("stream_we_%0d", i), {31'd0, rf_we}, 32'd1);
      end else begin
        checkOutput("stream_bubble_we", {31'd0, rf_we}, 32'd0);
      end
    end
    s2_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("stream_instret", instret, 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
